// File: rtl/segment_scan_decoder.sv
// ---------------------------------------------------------------------------
// segment_scan_decoder
//   Readback checker for a multiplexed 2-digit seven-segment display drive.
//   Samples the active-low anode enables and segment lines and debounces each
//   scan slot. It decodes the stable segment pattern back to a BCD digit, and
//   once both slots have been captured it publishes tens, units and the binary
//   value, together with a one-cycle frame_valid pulse.
//
// Ports
//   clk            in   1  single clock, rising edge
//   reset          in   1  asynchronous active-low reset
//   illuminate     in   8  anode enables, active-low; [0]=units, [1]=tens
//   seven_segment  in   8  segments, active-low; [7]=dp (ignored), [6:0]={g..a}
//   units          out  4  last accepted units digit (BCD)
//   tens           out  4  last accepted tens digit (BCD)
//   value          out  7  tens*10+units, binary
//   frame_valid    out  1  one-cycle pulse when units/tens/value update
//   seg_err        out  1  one-cycle pulse: stable non-digit pattern on a digit slot
//   anode_err      out  1  one-cycle pulse: stable illuminate with more than one bit low
// ---------------------------------------------------------------------------
module segment_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] illuminate,
    input  logic [7:0] seven_segment,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [6:0] value,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       anode_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    // Active-low segment pattern to {valid, digit}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = {1'b1, 4'd0};
            7'h79:   res = {1'b1, 4'd1};
            7'h24:   res = {1'b1, 4'd2};
            7'h30:   res = {1'b1, 4'd3};
            7'h19:   res = {1'b1, 4'd4};
            7'h12:   res = {1'b1, 4'd5};
            7'h02:   res = {1'b1, 4'd6};
            7'h78:   res = {1'b1, 4'd7};
            7'h00:   res = {1'b1, 4'd8};
            7'h10:   res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // Two BCD digits to binary; at most 99, so 7 bits always suffice.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] u);
        return ({3'b000, t} * 7'd10) + {3'b000, u};
    endfunction

    logic [14:0]   r_sample;
    logic [CW-1:0] r_count;
    logic          r_fire;
    logic [3:0]    r_pend_u;
    logic [3:0]    r_pend_t;
    logic          r_flag_u;
    logic          r_flag_t;

    logic [14:0]   w_sample_in;
    logic [CW-1:0] w_count_nxt;
    logic          w_fire_nxt;
    logic [7:0]    w_illum;
    logic [7:0]    w_low;
    logic [4:0]    w_dec;
    logic          w_units_slot;
    logic          w_tens_slot;
    logic          w_cap_u;
    logic          w_cap_t;
    logic          w_seg_bad;
    logic          w_anode_bad;
    logic          w_frame;

    // Run-length counter next state and one-shot accept detection.
    always_comb begin
        w_sample_in = {illuminate, seven_segment[6:0]};
        if (w_sample_in == r_sample) begin
            if (r_count == C_STABLE) begin
                w_count_nxt = r_count;
            end else begin
                w_count_nxt = r_count + C_ONE;
            end
        end else begin
            w_count_nxt = C_ONE;
        end
        // Fires only on the transition into saturation, so a long run accepts once.
        w_fire_nxt = (w_count_nxt == C_STABLE) && (r_count != C_STABLE);
    end

    // Classification of the accepted sample (r_sample still holds it while r_fire is high).
    always_comb begin
        w_illum      = r_sample[14:7];
        w_low        = ~w_illum;
        w_dec        = seg_decode(r_sample[6:0]);
        w_units_slot = r_fire && (w_illum == 8'hFE);
        w_tens_slot  = r_fire && (w_illum == 8'hFD);
        w_cap_u      = w_units_slot && w_dec[4];
        w_cap_t      = w_tens_slot && w_dec[4];
        w_seg_bad    = (w_units_slot || w_tens_slot) && !w_dec[4];
        // x & (x-1) clears the lowest set bit; non-zero means two or more anodes low.
        w_anode_bad  = r_fire && ((w_low & (w_low - 8'd1)) != 8'd0);
        w_frame      = r_flag_u && r_flag_t;
    end

    // Input sampling and run counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample <= 15'd0;
            r_count  <= '0;
            r_fire   <= 1'b0;
        end else begin
            r_sample <= w_sample_in;
            r_count  <= w_count_nxt;
            r_fire   <= w_fire_nxt;
        end
    end

    // Pending digits and captured flags; a capture coinciding with a frame seeds the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_u <= 4'd0;
            r_pend_t <= 4'd0;
            r_flag_u <= 1'b0;
            r_flag_t <= 1'b0;
        end else begin
            if (w_cap_u) begin
                r_pend_u <= w_dec[3:0];
            end else begin
                r_pend_u <= r_pend_u;
            end
            if (w_cap_t) begin
                r_pend_t <= w_dec[3:0];
            end else begin
                r_pend_t <= r_pend_t;
            end
            if (w_frame) begin
                r_flag_u <= w_cap_u;
                r_flag_t <= w_cap_t;
            end else begin
                r_flag_u <= r_flag_u | w_cap_u;
                r_flag_t <= r_flag_t | w_cap_t;
            end
        end
    end

    // Registered outputs: frame publication and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            units       <= 4'd0;
            tens        <= 4'd0;
            value       <= 7'd0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            if (w_frame) begin
                units       <= r_pend_u;
                tens        <= r_pend_t;
                value       <= bcd_to_bin(r_pend_t, r_pend_u);
                frame_valid <= 1'b1;
            end else begin
                frame_valid <= 1'b0;
            end
            seg_err   <= w_seg_bad;
            anode_err <= w_anode_bad;
        end
    end

endmodule
